// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional signed mode is enabled with the DIV_SIGNED_EN macro.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Widest dividend the all-ones constant below can cover
  localparam int MAX_W = 128;
  localparam logic [MAX_W-1:0] DIV0_QUOTIENT = '1;

  function automatic int cnt_width(input int dividend_w);
    return (dividend_w <= 1) ? 1 : $clog2(dividend_w);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus of the divider.
// Carries the is_signed request bit only when DIV_SIGNED_EN is defined.
interface seq_divider_if #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
`ifdef DIV_SIGNED_EN
  logic                  is_signed;
`endif
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
`ifdef DIV_SIGNED_EN
    output is_signed,
`endif
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
`ifdef DIV_SIGNED_EN
    input  is_signed,
`endif
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor and keep the difference only when it is non-negative.
module seq_divider_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);
  logic [W:0]   shifted;
  logic [W+1:0] diff;

  // The extra top bit of diff is the borrow, i.e. the sign of the trial result
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    q_bit   = ~diff[W+1];
    rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];
  end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN to add two's-complement operation selected by is_signed.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic          clk,
  input  logic          clr,
  seq_divider_if.slave  bus
);
  localparam int CNT_W = cnt_width(DIVIDEND_W);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W-1:0]  prem;
  logic [DIVISOR_W-1:0]  next_rem;
  logic                  q_bit;
  logic [DIVIDEND_W-1:0] a_mag;
  logic [DIVISOR_W-1:0]  b_mag;
  logic [DIVIDEND_W-1:0] q_raw;
  logic [DIVIDEND_W-1:0] q_res;
  logic [DIVISOR_W-1:0]  r_res;
`ifdef DIV_SIGNED_EN
  logic                  neg_q;
  logic                  neg_r;
`endif

  seq_divider_step #(.W(DIVISOR_W)) u_step (
    .rem_in  (prem),
    .bit_in  (dvd[DIVIDEND_W-1]),
    .divisor (dvs),
    .rem_out (next_rem),
    .q_bit   (q_bit)
  );

  // dvd shifts dividend bits out at the top while quotient bits fill the bottom
  always_comb begin
    q_raw = {dvd[DIVIDEND_W-2:0], q_bit};
`ifdef DIV_SIGNED_EN
    a_mag = (bus.is_signed && bus.dividend[DIVIDEND_W-1]) ? -bus.dividend : bus.dividend;
    b_mag = (bus.is_signed && bus.divisor[DIVISOR_W-1])   ? -bus.divisor  : bus.divisor;
    q_res = neg_q ? -q_raw : q_raw;
    r_res = neg_r ? -next_rem : next_rem;
`else
    a_mag = bus.dividend;
    b_mag = bus.divisor;
    q_res = q_raw;
    r_res = next_rem;
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state           <= IDLE;
      cnt             <= '0;
      dvd             <= '0;
      dvs             <= '0;
      prem            <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              state           <= DONE;
              bus.done        <= 1'b1;
              bus.quotient    <= DIV0_QUOTIENT[DIVIDEND_W-1:0];
              bus.remainder   <= '0;
              bus.div_by_zero <= 1'b1;
            end else begin
              state    <= CALC;
              bus.busy <= 1'b1;
              dvd      <= a_mag;
              dvs      <= b_mag;
              prem     <= '0;
              cnt      <= CNT_W'(DIVIDEND_W - 1);
`ifdef DIV_SIGNED_EN
              neg_q    <= bus.is_signed && (bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1]);
              neg_r    <= bus.is_signed && bus.dividend[DIVIDEND_W-1];
`endif
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          dvd  <= q_raw;
          prem <= next_rem;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state           <= DONE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.quotient    <= q_res;
            bus.remainder   <= r_res;
            bus.div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a default 16/8 instance driven from a vector
// table plus corner sequences, and a 32/16 instance driven with random operands.
module tb_seq_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    int          busy;
  } exp_t;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } vec_t;

  logic clk;
  logic clr;
  int   checks;
  int   failures;
  int   cyc;
  int   busy_total;
  int   t_accept;
  int   busy_base;
  logic [15:0] last_q;
  exp_t sb[$];
  exp_t sb32[$];
  vec_t vecs[10];

  seq_divider_if #(.DIVIDEND_W(16), .DIVISOR_W(8))  bus16 ();
  seq_divider_if #(.DIVIDEND_W(32), .DIVISOR_W(16)) bus32 ();

  seq_divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus16)
  );

  seq_divider #(.DIVIDEND_W(32), .DIVISOR_W(16)) u_dut32 (
    .clk (clk),
    .clr (clr),
    .bus (bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // busy is sampled mid-cycle so every high cycle is counted exactly once
  always @(negedge clk) if (bus16.busy === 1'b1) busy_total <= busy_total + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives one request in the current cycle and returns just after the accepting edge
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b,
                               input logic [15:0] q, input logic [7:0] r, input logic dz);
    exp_t e;
    e.q    = {16'h0, q};
    e.r    = {24'h0, r};
    e.dz   = dz;
    e.lat  = dz ? 1 : 17;
    e.busy = dz ? 0 : 16;
    sb.push_back(e);
    bus16.dividend = a;
    bus16.divisor  = b;
    bus16.start    = 1'b1;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    t_accept    = cyc;
    busy_base   = busy_total;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    int   guard;
    guard = 0;
    while (bus16.done !== 1'b1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check({tag, "_done_seen"}, {31'h0, bus16.done}, 32'h1);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard"}, 32'h0, 32'h1);
    end else begin
      e = sb.pop_front();
      check({tag, "_quotient"}, {16'h0, bus16.quotient}, e.q);
      check({tag, "_remainder"}, {24'h0, bus16.remainder}, e.r);
      check({tag, "_div_by_zero"}, {31'h0, bus16.div_by_zero}, {31'h0, e.dz});
      check({tag, "_latency"}, cyc - t_accept + 1, e.lat);
      check({tag, "_busy_cycles"}, busy_total - busy_base, e.busy);
      last_q = e.q[15:0];
    end
  endtask

  initial begin
    int done_hits;
    int guard;
    logic [31:0] a32;
    logic [15:0] b32;
    exp_t e32;

    vecs[0] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0};
    vecs[1] = '{16'd1000, 8'd7,  16'd142,  8'd6,  1'b0};
    vecs[2] = '{16'd5,    8'd0,  16'hFFFF, 8'h00, 1'b1};
    vecs[3] = '{16'd9,    8'd3,  16'd3,    8'd0,  1'b0};
    vecs[4] = '{16'd12345, 8'd100, 16'd123, 8'd45, 1'b0};
    vecs[5] = '{16'd255,  8'd16, 16'd15,   8'd15, 1'b0};
    vecs[6] = '{16'd1,    8'd255, 16'd0,   8'd1,  1'b0};
    vecs[7] = '{16'hFFFF, 8'd1,  16'hFFFF, 8'd0,  1'b0};
    vecs[8] = '{16'hABCD, 8'd127, 16'd346, 8'd39, 1'b0};
    vecs[9] = '{16'd200,  8'd201, 16'd0,   8'd200, 1'b0};

    checks = 0;
    failures = 0;
    clr = 1'b1;
    bus16.start = 1'b0;
    bus16.dividend = '0;
    bus16.divisor = '0;
    bus32.start = 1'b0;
    bus32.dividend = '0;
    bus32.divisor = '0;
`ifdef DIV_SIGNED_EN
    bus16.is_signed = 1'b0;
    bus32.is_signed = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, bus16.busy}, 32'h0);
    check("rst_done", {31'h0, bus16.done}, 32'h0);
    check("rst_quotient", {16'h0, bus16.quotient}, 32'h0);
    check("rst_remainder", {24'h0, bus16.remainder}, 32'h0);
    check("rst_div_by_zero", {31'h0, bus16.div_by_zero}, 32'h0);
    check("rst32_quotient", bus32.quotient, 32'h0);
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dz);
      checkOutput($sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), {31'h0, bus16.done}, 32'h0);
      check($sformatf("vec%0d_hold_q", i), {16'h0, bus16.quotient}, {16'h0, last_q});
    end

    $display("[TB] back-to-back start in DONE cycle");
    @(negedge clk);
    applyStimulus(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
    checkOutput("b2b_first");
    applyStimulus(16'd0, 8'd3, 16'd0, 8'd0, 1'b0);
    checkOutput("b2b_second");

    $display("[TB] start and operand changes during CALC are ignored");
    @(negedge clk);
    applyStimulus(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus16.dividend = 16'd50;
    bus16.divisor  = 8'd2;
    bus16.start    = 1'b1;
    @(posedge clk);
    #1;
    bus16.start    = 1'b0;
    bus16.dividend = 16'd77;
    bus16.divisor  = 8'd9;
    check("ignore_busy", {31'h0, bus16.busy}, 32'h1);
    checkOutput("ignore");

    $display("[TB] clr during CALC aborts the operation");
    @(negedge clk);
    bus16.dividend = 16'd1000;
    bus16.divisor  = 8'd7;
    bus16.start    = 1'b1;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", {31'h0, bus16.busy}, 32'h1);
    clr = 1'b1;
    #1;
    check("abort_busy", {31'h0, bus16.busy}, 32'h0);
    check("abort_quotient", {16'h0, bus16.quotient}, 32'h0);
    check("abort_remainder", {24'h0, bus16.remainder}, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    done_hits = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (bus16.done === 1'b1) done_hits++;
    end
    check("abort_no_done", done_hits, 0);

    $display("[TB] clr together with start");
    @(negedge clk);
    clr = 1'b1;
    bus16.dividend = 16'd100;
    bus16.divisor  = 8'd10;
    bus16.start    = 1'b1;
    @(posedge clk);
    #1;
    check("clr_wins_busy", {31'h0, bus16.busy}, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    bus16.start = 1'b0;
    @(negedge clk);
    applyStimulus(16'd9, 8'd3, 16'd3, 8'd0, 1'b0);
    checkOutput("after_clr");

`ifdef DIV_SIGNED_EN
    $display("[TB] signed operation");
    bus16.is_signed = 1'b1;
    @(negedge clk);
    applyStimulus(16'hFF9C, 8'd7, 16'hFFF2, 8'hFE, 1'b0);
    checkOutput("signed_neg100_7");
    @(negedge clk);
    applyStimulus(16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0);
    checkOutput("signed_minneg");
    @(negedge clk);
    applyStimulus(16'hFF9C, 8'd0, 16'hFFFF, 8'h00, 1'b1);
    checkOutput("signed_div0");
    bus16.is_signed = 1'b0;
`endif

    $display("[TB] 32/16 random operands");
    for (int i = 0; i < 6; i++) begin
      a32 = $urandom;
      b32 = (i == 0) ? 16'd1 : 16'($urandom_range(1, 65535));
      e32.q    = a32 / {16'h0, b32};
      e32.r    = a32 % {16'h0, b32};
      e32.dz   = 1'b0;
      e32.lat  = 33;
      e32.busy = 0;
      sb32.push_back(e32);
      @(negedge clk);
      bus32.dividend = a32;
      bus32.divisor  = b32;
      bus32.start    = 1'b1;
      @(posedge clk);
      #1;
      bus32.start = 1'b0;
      t_accept = cyc;
      guard = 0;
      while (bus32.done !== 1'b1 && guard < 100) begin
        @(posedge clk);
        #1;
        guard++;
      end
      e32 = sb32.pop_front();
      check($sformatf("w32_%0d_quotient", i), bus32.quotient, e32.q);
      check($sformatf("w32_%0d_remainder", i), {16'h0, bus32.remainder}, e32.r);
      check($sformatf("w32_%0d_latency", i), cyc - t_accept + 1, e32.lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle restoring divider with a start/done handshake. Replaces the fixed 16-by-8, single-evaluation divider with a width-configurable, one-quotient-bit-per-cycle datapath. It serves as the shared integer-division engine for arithmetic blocks in the design. Results are registered and held until the next operation, and divide-by-zero is flagged explicitly rather than driven to high impedance.

## Interface
- DIVIDEND_W, 16, dividend and quotient width; must be ≥ DIVISOR_W.
- DIVISOR_W, 8, divisor and remainder width; minimum 2.
- clk  in  1  clock; all state updates on posedge.
- clr  in  1  reset; asynchronous, active-high. Clears all state and outputs.
- start  in  1  request; accepted only while busy=0.
- dividend  in  DIVIDEND_W  sampled on the accepting edge.
- divisor  in  DIVISOR_W  sampled on the accepting edge.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  out  DIVIDEND_W  registered result.
- remainder  out  DIVISOR_W  registered result; always satisfies remainder < divisor.
- div_by_zero  out  1  registered flag; updated together with done.

## Operation
- States:
  - IDLE: busy=0.
  - CALC: busy=1.
  - DONE: busy=0, done=1.
- Transitions:
  - IDLE or DONE, with start=1 and divisor≠0: capture operands, clear the partial remainder, load the iteration counter with DIVIDEND_W-1, go to CALC.
  - IDLE or DONE, with start=1 and divisor=0: go to DONE directly. Result: quotient = all ones, remainder = 0, div_by_zero = 1.
  - CALC: each cycle, shift the next dividend MSB into the partial remainder (DIVISOR_W+1 bits) and trial-subtract the divisor. If the result is non-negative, keep the difference and shift in a 1; otherwise restore and shift in a 0. Decrement the counter.
  - CALC, when counter = 0: register quotient and remainder, clear div_by_zero, go to DONE.
  - DONE with start=0: go to IDLE.
- start while busy=1 is ignored. Operand changes during CALC have no effect.
- Outputs change only on DONE entry or on clr. They hold across IDLE.
- A dividend of 0 takes the normal CALC path and produces 0/0.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE.
- Normal latency: start is accepted on edge 0. CALC occupies edges 1..DIVIDEND_W. done is high in the cycle after edge DIVIDEND_W+1, which is 17 cycles for the defaults.
- Divide-by-zero latency: done is high after edge 1.
- Back-to-back operation: start held during the DONE cycle is accepted, giving a throughput of one result per DIVIDEND_W+1 cycles.
- clr mid-CALC: the operation is aborted immediately. All outputs and state return to reset values and no done is produced. The next start behaves normally.
- clr asserted together with start: clr wins.

## Configuration
- DIV_SIGNED_EN defined: adds input port `is_signed` (1 bit), sampled with start.
  - When is_signed=1, operands are two's complement. Magnitudes are taken at capture, and the signs are applied when results are registered.
  - The quotient truncates toward zero. The remainder takes the sign of the dividend.
  - Latency is unchanged.
  - Most-negative dividend ÷ -1: quotient wraps to the most-negative value, remainder = 0, div_by_zero = 0.
  - Divide-by-zero behaviour is identical to the unsigned case.
- DIV_SIGNED_EN undefined: the port is absent and operation is unsigned only.

## Structure
- Package seq_divider_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the counter-width function $clog2(DIVIDEND_W);
  - the divide-by-zero quotient constant (all ones).
- Sub-module seq_divider_step: combinational single restoring iteration. Takes the partial remainder, incoming bit and divisor; returns the new partial remainder and quotient bit. It is instantiated once in the top-level FSM.

## Test plan
- Defaults, 16'hFFFF / 8'hFF → quotient=16'h0101, remainder=8'h00, div_by_zero=0; done exactly 17 cycles after start; busy high 16 cycles.
- 1000 / 7 → quotient=142 (16'h008E), remainder=6; a second start issued during the DONE cycle (0 / 3) → quotient=0, remainder=0 after a further 17 cycles.
- 5 / 0 → done 1 cycle after start, quotient=16'hFFFF, remainder=0, div_by_zero=1; a following 9 / 3 clears the flag and gives quotient=3, remainder=0.
- clr pulsed 8 cycles into CALC → all outputs 0, no done pulse; start during CALC with other operands is ignored (checked before the clr).
- DIV_SIGNED_EN, is_signed=1:
  - -100 / 7 → quotient=16'hFFF2 (-14), remainder=8'hFE (-2).
  - 16'h8000 / 8'hFF → quotient=16'h8000, remainder=0.
- DIVIDEND_W=32, DIVISOR_W=16, random operands against a reference model → done at 33 cycles; every result matches the model.
